// File: rtl/alu_flags_unit_pkg.sv
// rtl/alu_flags_unit_pkg.sv - shared widths, flag indices and ARM data-processing opcodes
package alu_flags_unit_pkg;

  localparam int DATA_W      = 32;
  localparam int FLAG_W      = 4;
  localparam int FLAG_N      = 3;
  localparam int FLAG_Z      = 2;
  localparam int FLAG_C      = 1;
  localparam int FLAG_V      = 0;
  localparam int FLAGS_START = 28;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } alu_op_e;

endpackage

// File: rtl/alu_flags_unit_if.sv
// rtl/alu_flags_unit_if.sv - operand/flag bus between the issuing stage and the ALU flags unit
interface alu_flags_unit_if;
  import alu_flags_unit_pkg::*;

  logic [3:0]        alu_op;
  logic [DATA_W-1:0] rn;
  logic [DATA_W-1:0] op2;
  logic              shifter_carry;
  logic [FLAG_W-1:0] flag_we;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] flags_next;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] cpsr;

  modport master (
    output alu_op, rn, op2, shifter_carry, flag_we,
    input  alu_result, flags_next, alu_result_q, cpsr
  );

  modport slave (
    input  alu_op, rn, op2, shifter_carry, flag_we,
    output alu_result, flags_next, alu_result_q, cpsr
  );

endinterface

// File: rtl/alu_flags_unit_alu_core.sv
// rtl/alu_flags_unit_alu_core.sv - combinational opcode decode, shared adder and NZCV generation
module alu_core
  import alu_flags_unit_pkg::*;
(
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] rn,
  input  logic [DATA_W-1:0] op2,
  input  logic              shifter_carry,
  input  logic              c_in,
  input  logic              v_in,
  output logic [DATA_W-1:0] alu_result,
  output logic [FLAG_W-1:0] flags_next
);

  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic              is_arith;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] logic_res;

  // Every arithmetic op maps onto one adder: subtraction is A + ~B + (1 or C)
  always_comb begin
    add_a    = rn;
    add_b    = op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (alu_op_e'(alu_op))
      OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
      OP_RSB:         begin add_a = op2; add_b = ~rn; add_cin = 1'b1; end
      OP_ADD, OP_CMN: add_cin = 1'b0;
      OP_ADC:         add_cin = c_in;
      OP_SBC:         begin add_b = ~op2; add_cin = c_in; end
      OP_RSC:         begin add_a = op2; add_b = ~rn; add_cin = c_in; end
      default:        is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

  always_comb begin
    logic_res = '0;
    case (alu_op_e'(alu_op))
      OP_AND, OP_TST: logic_res = rn & op2;
      OP_EOR, OP_TEQ: logic_res = rn ^ op2;
      OP_ORR:         logic_res = rn | op2;
      OP_MOV:         logic_res = op2;
      OP_BIC:         logic_res = rn & ~op2;
      OP_MVN:         logic_res = ~op2;
      default:        logic_res = '0;
    endcase
  end

  always_comb begin
    alu_result = is_arith ? sum[DATA_W-1:0] : logic_res;
    flags_next         = '0;
    flags_next[FLAG_N] = alu_result[DATA_W-1];
    flags_next[FLAG_Z] = (alu_result == '0);
    if (is_arith) begin
      flags_next[FLAG_C] = sum[DATA_W];
      flags_next[FLAG_V] = (add_a[DATA_W-1] == add_b[DATA_W-1]) &&
                           (sum[DATA_W-1] != add_a[DATA_W-1]);
    end else begin
      flags_next[FLAG_C] = shifter_carry;
      flags_next[FLAG_V] = v_in;
    end
  end

endmodule

// File: rtl/alu_flags_unit.sv
// rtl/alu_flags_unit.sv - ALU with masked NZCV write-back into a CPSR and a registered result
module alu_flags_unit
  import alu_flags_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  alu_flags_unit_if.slave    bus
);

  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] flags_next;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic [FLAG_W-1:0] flags_d, flags_q;

  alu_core u_alu_core (
    .alu_op        (bus.alu_op),
    .rn            (bus.rn),
    .op2           (bus.op2),
    .shifter_carry (bus.shifter_carry),
    .c_in          (flags_q[FLAG_C]),
    .v_in          (flags_q[FLAG_V]),
    .alu_result    (alu_result),
    .flags_next    (flags_next)
  );

  always_comb begin
    alu_result_d = alu_result;
    flags_d      = (flags_q & ~bus.flag_we) | (flags_next & bus.flag_we);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q <= '0;
      flags_q      <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.alu_result   = alu_result;
  assign bus.flags_next   = flags_next;
  assign bus.alu_result_q = alu_result_q;
  assign bus.cpsr         = {{(DATA_W-FLAG_W){1'b0}}, flags_q} << FLAGS_START;

endmodule

// File: tb/tb_alu_flags_unit.sv
// tb/tb_alu_flags_unit.sv - directed and random checks of alu_flags_unit against a reference model
module tb_alu_flags_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_flags_unit_if bif();

  alu_flags_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic [31:0] res_q;
    logic [31:0] cpsr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  m_flags;
  logic [31:0] last_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference: add/sub evaluated in 64-bit unsigned and signed arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic sc, input logic [3:0] fl,
                                output logic [31:0] res, output logic [3:0] nf);
    longint unsigned ua, ub, ur;
    longint sa, sb, sr;
    logic c, v, bw;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = sc;
    v = fl[0];
    bw = ~fl[1];
    res = '0;
    case (op)
      4'h0, 4'h8: res = a & b;
      4'h1, 4'h9: res = a ^ b;
      4'hC: res = a | b;
      4'hD: res = b;
      4'hE: res = a & ~b;
      4'hF: res = ~b;
      4'h4, 4'hB, 4'h5: begin
        ur = ua + ub + ((op == 4'h5) ? {63'b0, fl[1]} : 64'd0);
        sr = sa + sb + ((op == 4'h5) ? longint'(fl[1]) : 64'sd0);
        res = ur[31:0];
        c = (ur > 64'hFFFF_FFFF);
        v = ovf(sr);
      end
      4'h2, 4'hA, 4'h6: begin
        if (op != 4'h6) bw = 1'b0;
        ur = ua - ub - {63'b0, bw};
        sr = sa - sb - longint'(bw);
        res = ur[31:0];
        c = (ua >= ub + {63'b0, bw});
        v = ovf(sr);
      end
      default: begin
        if (op != 4'h7) bw = 1'b0;
        ur = ub - ua - {63'b0, bw};
        sr = sb - sa - longint'(bw);
        res = ur[31:0];
        c = (ub >= ua + {63'b0, bw});
        v = ovf(sr);
      end
    endcase
    nf = {res[31], res == 32'b0, c, v};
  endfunction

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sc, input logic [3:0] we, input logic rst);
    logic [31:0] eres;
    logic [3:0]  enf;
    exp_t        e;
    bif.alu_op = op;
    bif.rn = a;
    bif.op2 = b;
    bif.shifter_carry = sc;
    bif.flag_we = we;
    reset = rst;
    #1;
    model(op, a, b, sc, m_flags, eres, enf);
    chk("alu_result", bif.alu_result, eres);
    chk("flags_next", {28'b0, bif.flags_next}, {28'b0, enf});
    if (rst) begin
      e.res_q = '0;
      e.cpsr  = '0;
    end else begin
      e.res_q = eres;
      e.cpsr  = {((m_flags & ~we) | (enf & we)), 28'b0};
    end
    sb_q.push_back(e);
    last_res = eres;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("alu_result_q", bif.alu_result_q, e.res_q);
      chk("cpsr", bif.cpsr, e.cpsr);
      m_flags = e.cpsr[31:28];
    end
  endtask

  initial begin
    bif.alu_op = '0;
    bif.rn = '0;
    bif.op2 = '0;
    bif.shifter_carry = 1'b0;
    bif.flag_we = '0;
    m_flags = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cpsr", bif.cpsr, 32'h0);
    chk("reset_res_q", bif.alu_result_q, 32'h0);

    step(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'hF, 1'b0);
    chk("add_ovf_res", last_res, 32'h8000_0000);
    chk("add_ovf_flags", {28'b0, bif.cpsr[31:28]}, 32'h9);

    step(4'h2, 32'd5, 32'd5, 1'b0, 4'hF, 1'b0);
    chk("sub_eq_flags", {28'b0, bif.cpsr[31:28]}, 32'h6);
    step(4'hA, 32'd5, 32'd5, 1'b0, 4'hF, 1'b0);
    chk("cmp_eq_flags", {28'b0, bif.cpsr[31:28]}, 32'h6);

    step(4'h5, 32'd1, 32'd2, 1'b0, 4'h0, 1'b0);
    chk("adc_c1", bif.alu_result_q, 32'd4);
    step(4'h6, 32'd5, 32'd3, 1'b0, 4'h0, 1'b0);
    chk("sbc_c1", bif.alu_result_q, 32'd2);
    step(4'h0, 32'h0, 32'h0, 1'b0, 4'h2, 1'b0);
    step(4'h5, 32'd1, 32'd2, 1'b0, 4'h0, 1'b0);
    chk("adc_c0", bif.alu_result_q, 32'd3);
    step(4'h6, 32'd5, 32'd3, 1'b0, 4'h0, 1'b0);
    chk("sbc_c0", bif.alu_result_q, 32'd1);

    step(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'hF, 1'b0);
    step(4'h0, 32'hF000_0000, 32'h8000_0000, 1'b1, 4'hF, 1'b0);
    chk("and_res", bif.alu_result_q, 32'h8000_0000);
    chk("and_keep_v", {28'b0, bif.cpsr[31:28]}, 32'hB);

    step(4'h0, 32'h0, 32'h0, 1'b0, 4'hF, 1'b1);
    step(4'h2, 32'd5, 32'd5, 1'b0, 4'h4, 1'b0);
    chk("mask_z_only", {28'b0, bif.cpsr[31:28]}, 32'h4);
    step(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h0, 1'b0);
    chk("mask_none", {28'b0, bif.cpsr[31:28]}, 32'h4);

    step(4'h2, 32'd5, 32'd5, 1'b0, 4'h6, 1'b0);
    step(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h9, 1'b0);
    chk("flags_all_set", {28'b0, bif.cpsr[31:28]}, 32'hF);
    step(4'h4, 32'd10, 32'd20, 1'b0, 4'hF, 1'b1);
    chk("midreset_cpsr", bif.cpsr, 32'h0);
    chk("midreset_res_q", bif.alu_result_q, 32'h0);
    step(4'h4, 32'd1, 32'd2, 1'b0, 4'hF, 1'b0);
    chk("resume_res_q", bif.alu_result_q, 32'd3);

    for (int i = 0; i < 48; i++) begin
      step(4'($urandom_range(0, 15)),
           (i % 4 == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : 32'($urandom),
           (i % 3 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_flags_unit.md
ALU_FLAGS_UNIT -- requirements
Module: alu_flags_unit

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, flag vector fixed at 4 bits ordered {N,Z,C,V} = [3:0].
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_op  input  4  ARM data-processing opcode.
REQ-005 rn  input  32  first operand (Rn).
REQ-006 op2  input  32  second operand (shifter output).
REQ-007 shifter_carry  input  1  shifter carry-out, used as C for logical ops.
REQ-008 flag_we  input  4  per-flag write mask {N,Z,C,V}; 1 = update that flag.
REQ-009 alu_result  output  32  combinational ALU result.
REQ-010 flags_next  output  4  combinational candidate flags {N,Z,C,V}.
REQ-011 alu_result_q  output  32  alu_result registered one cycle.
REQ-012 cpsr  output  32  status register; N,Z,C,V at bits 31,30,29,28; bits 27:0 always 0.

Function
REQ-013 Opcodes: 0 AND rn&op2; 1 EOR rn^op2; 2 SUB rn-op2; 3 RSB op2-rn; 4 ADD rn+op2; 5 ADC rn+op2+C; 6 SBC rn-op2-!C; 7 RSC op2-rn-!C; 8 TST as AND; 9 TEQ as EOR; A CMP as SUB; B CMN as ADD; C ORR rn|op2; D MOV op2; E BIC rn&~op2; F MVN ~op2.
REQ-014 Compare/test ops (8-B) SHALL drive alu_result with the computed value; suppressing register writeback is outside this block.
REQ-015 C input for ADC/SBC/RSC SHALL be cpsr[29] as currently registered.
REQ-016 All ops: N = alu_result[31]; Z = (alu_result == 0).
REQ-017 Arithmetic ops: C = carry-out of 33-bit add; for subtractions C = NOT borrow (A-B computed as A+~B+1 or A+~B+C).
REQ-018 Arithmetic ops: V = signed overflow (operands of effective addition share sign, result sign differs).
REQ-019 Logical ops (0,1,8,9,C,D,E,F): C = shifter_carry; V = current cpsr[28] (unchanged).
REQ-020 Results wrap modulo 2^32; no exceptions.
REQ-021 On each rising edge without reset, alu_result_q <= alu_result.
REQ-022 On each rising edge without reset, each cpsr flag bit loads flags_next bit where the flag_we bit is 1, else holds.
REQ-023 Flag update latency 1 cycle: an op in cycle n sees flags written by cycle n-1's op.
REQ-024 flag_we = 0000 SHALL leave cpsr unchanged; partial masks update only selected bits.

Reset
REQ-025 reset high at a rising edge SHALL force cpsr = 0x00000000 and alu_result_q = 0x00000000, overriding flag_we.
REQ-026 Combinational outputs are not reset; they follow inputs and the reset cpsr value.

Structure
REQ-027 Shared package: opcode constants (16), flag indices N=3/Z=2/C=1/V=0, FLAGS_START=28, widths 32/4.
REQ-028 One combinational sub-module alu_core (opcode decode, add/sub, flags); cpsr and output register inline in the top.

Verification
REQ-029 ADD rn=0x7FFFFFFF op2=1 flag_we=1111 -> alu_result 0x80000000; next cycle cpsr[31:28]=1001.
REQ-030 SUB rn=5 op2=5 flag_we=1111 -> result 0; cpsr[31:28]=0110; CMP same -> identical flags.
REQ-031 After C=1: ADC rn=1 op2=2 -> 4; SBC rn=5 op2=3 -> 2; with C=0 ADC -> 3, SBC -> 1.
REQ-032 With V=1 set, AND rn=0xF0000000 op2=0x80000000 shifter_carry=1 flag_we=1111 -> result 0x80000000, cpsr[31:28]=1011.
REQ-033 flag_we=0100 on SUB 5-5 from cpsr=0 -> only Z set (0100); flag_we=0000 -> no change.
REQ-034 Assert reset mid-stream after flags=1111 -> next edge cpsr=0, alu_result_q=0; ops resume the cycle after release.
